// File: rtl/fifo_serial_tx.sv
// Buffered serial link transmitter: queues flits and sends each as start bit + W data bits, MSB first.
// Build macro PARITY_EN appends an even-parity bit to every frame (the receiver must match).
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module fifo_serial_tx #(
  parameter int ID    = 1,
  parameter     DIR   = "east",
  parameter int DEPTH = 4,
  localparam int W    = `PAYLOAD_SIZE + `ADDR_BITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [W-1:0] parallel_in,
  output logic         tx_busy,
  input  logic         channel_busy,
  output logic         serial_out,
  output logic         tx_active
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(W);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_GAP} state_t;

  // ID and DIR only tag trace messages in simulation models; no hardware depends on them.
  if (ID < 0 || $bits(DIR) == 0) begin : g_label_unused
  end

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_sr;
  logic [W-1:0]  w_sr_nxt;
  logic [CW-1:0] r_bitcnt;
  logic [CW-1:0] w_bitcnt_nxt;
  logic          r_serial;
  logic          w_serial_nxt;
  logic          r_active;
  logic          w_active_nxt;
  logic          w_push;
  logic          w_pop;
`ifdef PARITY_EN
  logic          r_par;
  logic          w_par_nxt;
`endif

  assign tx_busy    = (r_count == FULL);
  assign w_push     = req && !tx_busy;
  assign serial_out = r_serial;
  assign tx_active  = r_active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= parallel_in;
  end

  // Line registers hold the value for the state being entered, so the line changes with the state.
  always_comb begin
    w_state_nxt  = r_state;
    w_sr_nxt     = r_sr;
    w_bitcnt_nxt = r_bitcnt;
    w_serial_nxt = 1'b0;
    w_active_nxt = 1'b0;
    w_pop        = 1'b0;
`ifdef PARITY_EN
    w_par_nxt    = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_count != '0 && !channel_busy) begin
          w_pop        = 1'b1;
          w_sr_nxt     = r_mem[r_rd_ptr];
`ifdef PARITY_EN
          w_par_nxt    = ^r_mem[r_rd_ptr];
`endif
          w_serial_nxt = 1'b1;
          w_active_nxt = 1'b1;
          w_state_nxt  = S_START;
        end
      end
      S_START: begin
        w_serial_nxt = r_sr[W-1];
        w_sr_nxt     = r_sr << 1;
        w_bitcnt_nxt = LAST_BIT;
        w_active_nxt = 1'b1;
        w_state_nxt  = S_DATA;
      end
      S_DATA: begin
        if (r_bitcnt == '0) begin
`ifdef PARITY_EN
          w_serial_nxt = r_par;
          w_active_nxt = 1'b1;
          w_state_nxt  = S_PAR;
`else
          w_state_nxt  = S_GAP;
`endif
        end else begin
          w_serial_nxt = r_sr[W-1];
          w_sr_nxt     = r_sr << 1;
          w_bitcnt_nxt = r_bitcnt - 1'b1;
          w_active_nxt = 1'b1;
        end
      end
`ifdef PARITY_EN
      S_PAR:   w_state_nxt = S_GAP;
`endif
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_serial <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_serial <= w_serial_nxt;
      r_active <= w_active_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_sr <= w_sr_nxt;
`ifdef PARITY_EN
    r_par <= w_par_nxt;
`endif
  end

endmodule
